// File: rtl/csr_pkg.sv
// Shared constants and FSM state type for the CSR write-port sequencer.
// Optional ebreak trap support is enabled with the CSR_EBREAK_EN macro in csr_trap_ctrl.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [2:0] F3_CSRRW  = 3'b001;
   localparam logic [2:0] F3_CSRRS  = 3'b010;
   localparam logic [2:0] F3_CSRRC  = 3'b011;
   localparam logic [2:0] F3_CSRRWI = 3'b101;
   localparam logic [2:0] F3_CSRRSI = 3'b110;
   localparam logic [2:0] F3_CSRRCI = 3'b111;

   localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
   localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_CSR_WR      = 3'd1,
      ST_TRAP_EPC    = 3'd2,
      ST_TRAP_CAUSE  = 3'd3,
      ST_TRAP_STATUS = 3'd4,
      ST_MRET_STATUS = 3'd5
   } csr_state_e;

endpackage

// File: rtl/csr_alu.sv
// Zicsr read-modify-write datapath: new CSR value and write enable from funct3/old/src.
module csr_alu
   import csr_pkg::*;
#(
   parameter int data_width = 32
) (
   input  logic [2:0]            i_funct3,
   input  logic [data_width-1:0] i_old,
   input  logic [data_width-1:0] i_src,
   output logic [data_width-1:0] o_new,
   output logic                  o_we
);

   always_comb begin
      o_new = i_old;
      o_we  = 1'b0;
      case (i_funct3)
         F3_CSRRW, F3_CSRRWI: begin
            o_new = i_src;
            o_we  = 1'b1;
         end
         F3_CSRRS, F3_CSRRSI: begin
            o_new = i_old | i_src;
            o_we  = |i_src;
         end
         F3_CSRRC, F3_CSRRCI: begin
            o_new = i_old & ~i_src;
            o_we  = |i_src;
         end
         // 000/100: read-only access, old value still goes to rd
         default: ;
      endcase
   end

endmodule

// File: rtl/csr_trap_ctrl.sv
// CSR write-port initiator: Zicsr read-modify-write, M-mode trap entry and mret sequencing.
// Define CSR_EBREAK_EN to add the ebreak_valid input (trap with cause 3, PC from ecall_pc).
module csr_trap_ctrl
   import csr_pkg::*;
#(
   parameter int data_width     = 32,
   parameter int csr_addr_width = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      csr_op_valid,
   input  logic [2:0]                csr_funct3,
   input  logic [csr_addr_width-1:0] csr_addr,
   input  logic [data_width-1:0]     rs1_data,
   input  logic [4:0]                zimm,
   input  logic                      ecall_valid,
   input  logic [data_width-1:0]     ecall_pc,
`ifdef CSR_EBREAK_EN
   input  logic                      ebreak_valid,
`endif
   input  logic                      mret_valid,
   output logic [csr_addr_width-1:0] csr_addr_r,
   input  logic [data_width-1:0]     csr_rdata,
   input  logic [data_width-1:0]     csr_mtvec,
   input  logic [data_width-1:0]     csr_mepc,
   input  logic [data_width-1:0]     csr_mstatus,
   output logic                      csr_we,
   output logic [csr_addr_width-1:0] csr_addr_w,
   output logic [data_width-1:0]     csr_wdata,
   output logic                      rd_valid,
   output logic [data_width-1:0]     rd_wdata,
   output logic                      stall,
   output logic                      redirect_valid,
   output logic [data_width-1:0]     redirect_pc,
   output logic [2:0]                dbg_state
);

   csr_state_e                r_state;
   logic [data_width-1:0]     r_old_q;
   logic [2:0]                r_funct3;
   logic [csr_addr_width-1:0] r_addr;
   logic [data_width-1:0]     r_src;
   logic [data_width-1:0]     r_pc_q;
   logic [data_width-1:0]     r_cause_q;

   logic                      w_ebreak;
   logic [data_width-1:0]     w_src_in;
   logic [data_width-1:0]     w_alu_new;
   logic                      w_alu_we;
   logic [data_width-1:0]     w_trap_mstatus;
   logic [data_width-1:0]     w_mret_mstatus;

`ifdef CSR_EBREAK_EN
   assign w_ebreak = ebreak_valid;
`else
   assign w_ebreak = 1'b0;
`endif

   assign w_src_in = csr_funct3[2] ? {{(data_width-5){1'b0}}, zimm} : rs1_data;

   csr_alu #(.data_width(data_width)) u_alu (
      .i_funct3 (r_funct3),
      .i_old    (r_old_q),
      .i_src    (r_src),
      .o_new    (w_alu_new),
      .o_we     (w_alu_we)
   );

   // mstatus images are built from the live CSR view in the cycle they are written
   always_comb begin
      w_trap_mstatus                                = csr_mstatus;
      w_trap_mstatus[MSTATUS_MPIE]                  = csr_mstatus[MSTATUS_MIE];
      w_trap_mstatus[MSTATUS_MIE]                   = 1'b0;
      w_trap_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      w_mret_mstatus                                = csr_mstatus;
      w_mret_mstatus[MSTATUS_MIE]                   = csr_mstatus[MSTATUS_MPIE];
      w_mret_mstatus[MSTATUS_MPIE]                  = 1'b1;
      w_mret_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_old_q   <= '0;
         r_funct3  <= '0;
         r_addr    <= '0;
         r_src     <= '0;
         r_pc_q    <= '0;
         r_cause_q <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (ecall_valid) begin
                  r_pc_q    <= ecall_pc;
                  r_cause_q <= data_width'(CAUSE_ECALL_M);
                  r_state   <= ST_TRAP_EPC;
               end else if (w_ebreak) begin
                  r_pc_q    <= ecall_pc;
                  r_cause_q <= data_width'(CAUSE_BREAKPOINT);
                  r_state   <= ST_TRAP_EPC;
               end else if (mret_valid) begin
                  r_state <= ST_MRET_STATUS;
               end else if (csr_op_valid) begin
                  r_old_q  <= csr_rdata;
                  r_funct3 <= csr_funct3;
                  r_addr   <= csr_addr;
                  r_src    <= w_src_in;
                  r_state  <= ST_CSR_WR;
               end
            end
            ST_TRAP_EPC:   r_state <= ST_TRAP_CAUSE;
            ST_TRAP_CAUSE: r_state <= ST_TRAP_STATUS;
            default:       r_state <= ST_IDLE;
         endcase
      end
   end

   assign csr_addr_r = csr_addr;
   assign stall      = (r_state != ST_IDLE);
   assign dbg_state  = r_state;

   always_comb begin
      csr_we         = 1'b0;
      csr_addr_w     = '0;
      csr_wdata      = '0;
      rd_valid       = 1'b0;
      rd_wdata       = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      case (r_state)
         ST_CSR_WR: begin
            csr_we     = w_alu_we;
            csr_addr_w = r_addr;
            csr_wdata  = w_alu_new;
            rd_valid   = 1'b1;
            rd_wdata   = r_old_q;
         end
         ST_TRAP_EPC: begin
            csr_we     = 1'b1;
            csr_addr_w = csr_addr_width'(CSR_MEPC);
            csr_wdata  = {r_pc_q[data_width-1:2], 2'b00};
         end
         ST_TRAP_CAUSE: begin
            csr_we     = 1'b1;
            csr_addr_w = csr_addr_width'(CSR_MCAUSE);
            csr_wdata  = r_cause_q;
         end
         ST_TRAP_STATUS: begin
            csr_we         = 1'b1;
            csr_addr_w     = csr_addr_width'(CSR_MSTATUS);
            csr_wdata      = w_trap_mstatus;
            redirect_valid = 1'b1;
            redirect_pc    = {csr_mtvec[data_width-1:2], 2'b00};
         end
         ST_MRET_STATUS: begin
            csr_we         = 1'b1;
            csr_addr_w     = csr_addr_width'(CSR_MSTATUS);
            csr_wdata      = w_mret_mstatus;
            redirect_valid = 1'b1;
            redirect_pc    = csr_mepc;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: directed test-plan steps, then randomized ops against a CSR-file model.
module tb_csr_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_op_valid;
   logic [2:0]  csr_funct3;
   logic [11:0] csr_addr;
   logic [31:0] rs1_data;
   logic [4:0]  zimm;
   logic        ecall_valid;
   logic [31:0] ecall_pc;
`ifdef CSR_EBREAK_EN
   logic        ebreak_valid = 1'b0;
`endif
   logic        mret_valid;
   logic [11:0] csr_addr_r;
   logic [31:0] csr_rdata, csr_mtvec, csr_mepc, csr_mstatus;
   logic        csr_we;
   logic [11:0] csr_addr_w;
   logic [31:0] csr_wdata;
   logic        rd_valid;
   logic [31:0] rd_wdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [2:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   // CSR register file seen by the DUT, and the bench's expected image of it
   logic [31:0] csr_file [0:4095];
   logic [31:0] exp_csr  [0:4095];
   logic        env_clear;

   always #5 clk = ~clk;

   csr_trap_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .csr_op_valid   (csr_op_valid),
      .csr_funct3     (csr_funct3),
      .csr_addr       (csr_addr),
      .rs1_data       (rs1_data),
      .zimm           (zimm),
      .ecall_valid    (ecall_valid),
      .ecall_pc       (ecall_pc),
`ifdef CSR_EBREAK_EN
      .ebreak_valid   (ebreak_valid),
`endif
      .mret_valid     (mret_valid),
      .csr_addr_r     (csr_addr_r),
      .csr_rdata      (csr_rdata),
      .csr_mtvec      (csr_mtvec),
      .csr_mepc       (csr_mepc),
      .csr_mstatus    (csr_mstatus),
      .csr_we         (csr_we),
      .csr_addr_w     (csr_addr_w),
      .csr_wdata      (csr_wdata),
      .rd_valid       (rd_valid),
      .rd_wdata       (rd_wdata),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dbg_state      (dbg_state)
   );

   assign csr_rdata   = csr_file[csr_addr_r];
   assign csr_mtvec   = csr_file[12'h305];
   assign csr_mepc    = csr_file[12'h341];
   assign csr_mstatus = csr_file[12'h300];

   always @(posedge clk) begin
      if (env_clear) begin
         for (int i = 0; i < 4096; i++) csr_file[i] <= 32'd0;
      end else if (csr_we) begin
         csr_file[csr_addr_w] <= csr_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] trap_ms(input logic [31:0] ms);
      return (ms & ~32'h0000_1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800;
   endfunction

   function automatic logic [31:0] mret_ms(input logic [31:0] ms);
      return (ms & ~32'h0000_1888) | (ms[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
   endfunction

   task automatic do_csr(input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] rs1, input logic [4:0] zi);
      logic [31:0] src, old, nv;
      logic        we;
      src = f3[2] ? {27'd0, zi} : rs1;
      old = exp_csr[addr];
      case (f3[1:0])
         2'b01:   begin nv = src;        we = 1'b1;       end
         2'b10:   begin nv = old | src;  we = (src != 0); end
         2'b11:   begin nv = old & ~src; we = (src != 0); end
         default: begin nv = old;        we = 1'b0;       end
      endcase
      @(negedge clk);
      csr_op_valid = 1'b1; csr_funct3 = f3; csr_addr = addr; rs1_data = rs1; zimm = zi;
      #1;
      chk("op_idle_stall", {31'd0, stall}, 32'd0);
      chk("op_addr_r", {20'd0, csr_addr_r}, {20'd0, addr});
      @(negedge clk);
      csr_op_valid = 1'b0; csr_funct3 = 3'($urandom); csr_addr = 12'($urandom);
      rs1_data = $urandom; zimm = 5'($urandom);
      chk("op_c1_stall", {31'd0, stall}, 32'd1);
      chk("op_c1_rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("op_c1_rd_wdata", rd_wdata, old);
      chk("op_c1_we", {31'd0, csr_we}, {31'd0, we});
      chk("op_c1_redirect", {31'd0, redirect_valid}, 32'd0);
      if (we) begin
         chk("op_c1_addr_w", {20'd0, csr_addr_w}, {20'd0, addr});
         chk("op_c1_wdata", csr_wdata, nv);
         exp_csr[addr] = nv;
      end
      @(negedge clk);
      chk("op_c2_stall", {31'd0, stall}, 32'd0);
      chk("op_c2_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("op_c2_file", csr_file[addr], exp_csr[addr]);
   endtask

   task automatic do_trap(input logic [31:0] pc, input bit with_op);
      logic [31:0] ems, etvec, other;
      ems   = trap_ms(exp_csr[12'h300]);
      etvec = exp_csr[12'h305] & ~32'h3;
      other = exp_csr[12'h305];
      @(negedge clk);
      ecall_valid = 1'b1; ecall_pc = pc;
      if (with_op) begin
         csr_op_valid = 1'b1; csr_funct3 = 3'b001; csr_addr = 12'h305; rs1_data = 32'hdead_beef;
      end
      @(negedge clk);
      ecall_valid = 1'b0; ecall_pc = $urandom;
      chk("trap_c1_stall", {31'd0, stall}, 32'd1);
      chk("trap_c1_we", {31'd0, csr_we}, 32'd1);
      chk("trap_c1_addr", {20'd0, csr_addr_w}, 32'h341);
      chk("trap_c1_wdata", csr_wdata, pc & ~32'h3);
      chk("trap_c1_redirect", {31'd0, redirect_valid}, 32'd0);
      chk("trap_c1_rd_valid", {31'd0, rd_valid}, 32'd0);
      @(negedge clk);
      chk("trap_c2_we", {31'd0, csr_we}, 32'd1);
      chk("trap_c2_addr", {20'd0, csr_addr_w}, 32'h342);
      chk("trap_c2_wdata", csr_wdata, 32'd11);
      chk("trap_c2_redirect", {31'd0, redirect_valid}, 32'd0);
      @(negedge clk);
      csr_op_valid = 1'b0;
      chk("trap_c3_stall", {31'd0, stall}, 32'd1);
      chk("trap_c3_addr", {20'd0, csr_addr_w}, 32'h300);
      chk("trap_c3_wdata", csr_wdata, ems);
      chk("trap_c3_redirect", {31'd0, redirect_valid}, 32'd1);
      chk("trap_c3_pc", redirect_pc, etvec);
      exp_csr[12'h341] = pc & ~32'h3;
      exp_csr[12'h342] = 32'd11;
      exp_csr[12'h300] = ems;
      @(negedge clk);
      chk("trap_c4_stall", {31'd0, stall}, 32'd0);
      chk("trap_c4_redirect", {31'd0, redirect_valid}, 32'd0);
      chk("trap_c4_we", {31'd0, csr_we}, 32'd0);
      chk("trap_mepc", csr_file[12'h341], exp_csr[12'h341]);
      chk("trap_mcause", csr_file[12'h342], exp_csr[12'h342]);
      chk("trap_mstatus", csr_file[12'h300], exp_csr[12'h300]);
      @(negedge clk);
      chk("trap_c5_stall", {31'd0, stall}, 32'd0);
      chk("trap_mtvec_kept", csr_file[12'h305], other);
   endtask

   task automatic do_mret();
      logic [31:0] ems, epc;
      ems = mret_ms(exp_csr[12'h300]);
      epc = exp_csr[12'h341];
      @(negedge clk);
      mret_valid = 1'b1;
      @(negedge clk);
      mret_valid = 1'b0;
      chk("mret_c1_stall", {31'd0, stall}, 32'd1);
      chk("mret_c1_we", {31'd0, csr_we}, 32'd1);
      chk("mret_c1_addr", {20'd0, csr_addr_w}, 32'h300);
      chk("mret_c1_wdata", csr_wdata, ems);
      chk("mret_c1_redirect", {31'd0, redirect_valid}, 32'd1);
      chk("mret_c1_pc", redirect_pc, epc);
      exp_csr[12'h300] = ems;
      @(negedge clk);
      chk("mret_c2_stall", {31'd0, stall}, 32'd0);
      chk("mret_c2_redirect", {31'd0, redirect_valid}, 32'd0);
      chk("mret_mstatus", csr_file[12'h300], exp_csr[12'h300]);
   endtask

   initial begin
      logic [11:0] addr_pool [5];
      addr_pool[0] = 12'h300; addr_pool[1] = 12'h305; addr_pool[2] = 12'h341;
      addr_pool[3] = 12'h342; addr_pool[4] = 12'h340;
      for (int i = 0; i < 4096; i++) exp_csr[i] = 32'd0;

      rst = 1'b0; env_clear = 1'b1;
      csr_op_valid = 1'b0; csr_funct3 = 3'd0; csr_addr = 12'd0; rs1_data = 32'd0; zimm = 5'd0;
      ecall_valid = 1'b0; ecall_pc = 32'd0; mret_valid = 1'b0;
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_we", {31'd0, csr_we}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
      chk("rst_wdata", csr_wdata, 32'd0);
      chk("rst_addr_w", {20'd0, csr_addr_w}, 32'd0);
      chk("rst_rd_wdata", rd_wdata, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      repeat (2) @(negedge clk);
      env_clear = 1'b0; rst = 1'b1;

      // preload mtvec and mstatus through the DUT itself
      do_csr(3'b001, 12'h305, 32'h170, 5'd0);
      do_csr(3'b001, 12'h300, 32'h1800, 5'd0);
      do_csr(3'b001, 12'h305, 32'h200, 5'd0);   // old 0x170 -> rd, write 0x200
      do_csr(3'b010, 12'h305, 32'h0, 5'd0);     // read back 0x200, no write
      do_csr(3'b010, 12'h300, 32'h8, 5'd0);     // 0x1800 -> 0x1808
      do_csr(3'b111, 12'h300, 32'hffff_ffff, 5'd0);
      do_csr(3'b001, 12'h305, 32'h171, 5'd0);
      do_trap(32'h40, 1'b0);                    // mstatus 0x1880, redirect 0x170
      do_csr(3'b001, 12'h341, 32'h44, 5'd0);
      do_mret();                                // mstatus 0x1888, redirect 0x44
      do_trap(32'h83, 1'b1);                    // CSR op alongside and during the trap
      do_csr(3'b000, 12'h305, 32'h55, 5'd3);
      do_csr(3'b100, 12'h300, 32'h0, 5'd7);
      do_csr(3'b101, 12'h340, 32'h0, 5'd21);

      for (int n = 0; n < 40; n++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel == 0) do_trap($urandom, 1'($urandom_range(0, 1)));
         else if (sel == 1) do_mret();
         else do_csr(3'($urandom), addr_pool[$urandom_range(0, 4)],
                     ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 5'($urandom));
      end

      // reset while the trap sequence is in its mcause cycle
      @(negedge clk);
      ecall_valid = 1'b1; ecall_pc = 32'h40;
      @(negedge clk);
      ecall_valid = 1'b0;
      exp_csr[12'h341] = 32'h40;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_stall", {31'd0, stall}, 32'd0);
      chk("mid_rst_we", {31'd0, csr_we}, 32'd0);
      chk("mid_rst_redirect", {31'd0, redirect_valid}, 32'd0);
      chk("mid_rst_wdata", csr_wdata, 32'd0);
      chk("mid_rst_state", {29'd0, dbg_state}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_rst_redirect", {31'd0, redirect_valid}, 32'd0);
         chk("post_rst_stall", {31'd0, stall}, 32'd0);
      end
      chk("post_rst_mepc", csr_file[12'h341], 32'h40);
      chk("post_rst_mcause", csr_file[12'h342], exp_csr[12'h342]);
      chk("post_rst_mstatus", csr_file[12'h300], exp_csr[12'h300]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
